// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a program as a valid/ready word stream,
// writes each word to sequential imem addresses, verifies a trailing checksum
// word, and releases the CPU from reset only after a successful load.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start_i,
  input  logic [15:0] load_len_i,
  input  logic        word_valid_i,
  input  logic [31:0] word_data_i,
  output logic        word_ready_o,
  output logic        wr_en_imem_o,
  output logic [31:0] wr_addr_imem_o,
  output logic [31:0] wr_instr_imem_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] checksum_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] count;
  logic [15:0] len_q;
  logic        xfer;
  logic        can_start;
  logic        len_ok;
  logic        last_word;
  logic        busy_d;
  logic        done_d;
  logic        err_d;
  logic        cpu_rst_d;

  // Ready is a pure decode of the registered state, so it never depends on inputs.
  assign word_ready_o = (state == LOAD) || (state == CSUM);
  assign xfer         = word_valid_i && word_ready_o;
  assign can_start    = load_start_i &&
                        ((state == IDLE) || (state == DONE) || (state == ERR));
  assign len_ok       = (load_len_i != '0) && (32'(load_len_i) <= DEPTH_WORDS);
  assign last_word    = (count == (len_q - 16'd1));

  // State register and registered status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      cpu_reset_o <= 1'b0;
    end else begin
      state       <= next_state;
      busy_o      <= busy_d;
      done_o      <= done_d;
      err_o       <= err_d;
      cpu_reset_o <= cpu_rst_d;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (load_start_i) begin
          next_state = len_ok ? LOAD : ERR;
        end
      end
      LOAD: begin
        if (word_valid_i && last_word) begin
          next_state = CSUM;
        end
      end
      CSUM: begin
        if (word_valid_i) begin
          next_state = (word_data_i == checksum_o) ? DONE : ERR;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Status flags are computed from the next state so that the registered
  // copies line up exactly with the state register.
  always_comb begin
    busy_d    = (next_state == LOAD) || (next_state == CSUM);
    done_d    = (next_state == DONE);
    err_d     = (next_state == ERR);
    cpu_rst_d = (next_state == DONE);
  end

  // Datapath: word counter, running checksum and the imem write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      count           <= '0;
      len_q           <= '0;
      checksum_o      <= '0;
      wr_en_imem_o    <= 1'b0;
      wr_addr_imem_o  <= BASE_ADDR;
      wr_instr_imem_o <= '0;
    end else begin
      wr_en_imem_o <= 1'b0;
      if (can_start && len_ok) begin
        count      <= '0;
        len_q      <= load_len_i;
        checksum_o <= '0;
      end else if (xfer && (state == LOAD)) begin
        wr_en_imem_o    <= 1'b1;
        wr_addr_imem_o  <= BASE_ADDR + {14'd0, count, 2'b00};
        wr_instr_imem_o <= word_data_i;
        checksum_o      <= checksum_o + word_data_i;
        count           <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized programs and handshakes are
// compared against a write log built from plain arithmetic on the program.
module tb_imem_loader;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        clk;
  logic        reset;
  logic        load_start_i;
  logic [15:0] load_len_i;
  logic        word_valid_i;
  logic [31:0] word_data_i;
  logic        word_ready_o;
  logic        wr_en_imem_o;
  logic [31:0] wr_addr_imem_o;
  logic [31:0] wr_instr_imem_o;
  logic        cpu_reset_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] checksum_o;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int inject_at = -1;

  logic [31:0] prog [0:15];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  int          log_cyc  [$];
  bit          pat [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start_i   (load_start_i),
    .load_len_i     (load_len_i),
    .word_valid_i   (word_valid_i),
    .word_data_i    (word_data_i),
    .word_ready_o   (word_ready_o),
    .wr_en_imem_o   (wr_en_imem_o),
    .wr_addr_imem_o (wr_addr_imem_o),
    .wr_instr_imem_o(wr_instr_imem_o),
    .cpu_reset_o    (cpu_reset_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .checksum_o     (checksum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Record every memory write with the cycle it appeared in
  always @(negedge clk) begin
    if (wr_en_imem_o === 1'b1) begin
      log_addr.push_back(wr_addr_imem_o);
      log_data.push_back(wr_instr_imem_o);
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic do_start(input logic [15:0] len, input string tag);
    bit ok;
    ok = (len != 16'd0) && (32'(len) <= DEPTH);
    clear_log();
    @(negedge clk);
    load_start_i = 1'b1;
    load_len_i   = len;
    @(negedge clk);
    load_start_i = 1'b0;
    load_len_i   = 16'($urandom);
    tests++;
    if (busy_o !== ok || err_o !== !ok || done_o !== 1'b0 || cpu_reset_o !== 1'b0) begin
      failed++;
      $display("FAIL %s_start: busy/err/done/cpu_rst got %b%b%b%b exp %b%b00",
               tag, busy_o, err_o, done_o, cpu_reset_o, ok, !ok);
    end
    if (ok) begin
      tests++;
      if (checksum_o !== 32'd0) begin
        failed++;
        $display("FAIL %s_start_csum: got %h exp 00000000", tag, checksum_o);
      end
    end
  endtask

  // mode 0: always valid, 1: random valid, 2: fixed toggle pattern
  task automatic stream(input int n, input logic [31:0] csw, input int mode, input string tag);
    int idx = 0;
    int pi = 0;
    logic [31:0] sum = '0;
    bit v;
    while (idx < n + 1 && pi < 2000) begin
      @(negedge clk);
      tests++;
      if (checksum_o !== sum) begin
        failed++;
        $display("FAIL %s_running_csum: got %h exp %h after %0d words", tag, checksum_o, sum, idx);
      end
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = 1'($urandom_range(0, 1));
      else                v = (pi < 7) ? pat[pi] : 1'b1;
      load_start_i = (pi == inject_at);
      load_len_i   = (pi == inject_at) ? 16'd9 : 16'd0;
      word_valid_i = v;
      word_data_i  = v ? ((idx < n) ? prog[idx] : csw) : $urandom;
      if (v && word_ready_o === 1'b1) begin
        if (idx < n) sum += prog[idx];
        idx++;
      end
      pi++;
    end
    @(negedge clk);
    word_valid_i = 1'b0;
    load_start_i = 1'b0;
    if (idx < n + 1) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout: accepted %0d exp %0d words", tag, idx, n + 1);
    end
  endtask

  task automatic check_result(input int n, input logic [31:0] csw, input string tag);
    logic [31:0] sum = '0;
    bit good;
    for (int k = 0; k < n; k++) sum += prog[k];
    good = (csw == sum);
    repeat (2) @(negedge clk);
    tests++;
    if (log_addr.size() != n) begin
      failed++;
      $display("FAIL %s_write_count: got %0d exp %0d", tag, log_addr.size(), n);
    end
    for (int k = 0; k < n && k < log_addr.size(); k++) begin
      tests++;
      if (log_addr[k] !== BASE + 32'(4 * k) || log_data[k] !== prog[k]) begin
        failed++;
        $display("FAIL %s_write%0d: got %h:%h exp %h:%h", tag, k,
                 log_addr[k], log_data[k], BASE + 32'(4 * k), prog[k]);
      end
    end
    tests++;
    if (done_o !== good || err_o !== !good || cpu_reset_o !== good ||
        busy_o !== 1'b0 || word_ready_o !== 1'b0) begin
      failed++;
      $display("FAIL %s_final_flags: done/err/cpu_rst/busy/ready got %b%b%b%b%b exp %b%b%b00",
               tag, done_o, err_o, cpu_reset_o, busy_o, word_ready_o, good, !good, good);
    end
    tests++;
    if (checksum_o !== sum) begin
      failed++;
      $display("FAIL %s_final_csum: got %h exp %h", tag, checksum_o, sum);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || cpu_reset_o !== 1'b0 ||
        word_ready_o !== 1'b0 || wr_en_imem_o !== 1'b0) begin
      failed++;
      $display("FAIL %s_flags: busy/done/err/cpu_rst/ready/wr_en got %b%b%b%b%b%b exp 000000",
               tag, busy_o, done_o, err_o, cpu_reset_o, word_ready_o, wr_en_imem_o);
    end
    tests++;
    if (checksum_o !== 32'd0 || wr_addr_imem_o !== BASE || wr_instr_imem_o !== 32'd0) begin
      failed++;
      $display("FAIL %s_regs: csum/addr/instr got %h/%h/%h exp 00000000/%h/00000000",
               tag, checksum_o, wr_addr_imem_o, wr_instr_imem_o, BASE);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
  endtask

  task automatic test_basic();
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33;
    do_start(16'd3, "basic");
    stream(3, 32'h66, 0, "basic");
    check_result(3, 32'h66, "basic");
  endtask

  task automatic test_bad_csum();
    prog[0] = 32'h11; prog[1] = 32'h22; prog[2] = 32'h33;
    do_start(16'd3, "badcsum");
    stream(3, 32'h67, 0, "badcsum");
    check_result(3, 32'h67, "badcsum");
  endtask

  task automatic bad_len_case(input logic [15:0] len, input string tag);
    bit saw_ready = 1'b0;
    do_start(len, tag);
    for (int i = 0; i < 6; i++) begin
      word_valid_i = 1'b1;
      word_data_i  = $urandom;
      @(negedge clk);
      if (word_ready_o !== 1'b0 || err_o !== 1'b1) saw_ready = 1'b1;
    end
    word_valid_i = 1'b0;
    tests++;
    if (saw_ready) begin
      failed++;
      $display("FAIL %s_hold: ready/err got %b%b exp 01", tag, word_ready_o, err_o);
    end
    tests++;
    if (log_addr.size() != 0) begin
      failed++;
      $display("FAIL %s_writes: got %0d exp 0", tag, log_addr.size());
    end
  endtask

  task automatic test_bad_len();
    bad_len_case(16'd0, "len0");
    bad_len_case(16'(DEPTH + 1), "lenover");
  endtask

  task automatic test_stall();
    logic [31:0] s = '0;
    for (int k = 0; k < 4; k++) begin prog[k] = $urandom; s += prog[k]; end
    do_start(16'd4, "stall");
    stream(4, s, 2, "stall");
    check_result(4, s, "stall");
  endtask

  task automatic test_back_to_back();
    logic [31:0] s = '0;
    for (int k = 0; k < 16; k++) begin prog[k] = $urandom; s += prog[k]; end
    do_start(16'(DEPTH), "b2b");
    stream(16, s, 0, "b2b");
    check_result(16, s, "b2b");
    for (int k = 1; k < log_cyc.size(); k++) begin
      tests++;
      if (log_cyc[k] !== log_cyc[k-1] + 1) begin
        failed++;
        $display("FAIL b2b_gap%0d: got cycle %0d exp %0d", k, log_cyc[k], log_cyc[k-1] + 1);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] s = '0;
    for (int k = 0; k < 2; k++) begin prog[k] = $urandom; s += prog[k]; end
    do_start(16'd2, "ignore");
    inject_at = 0;
    stream(2, s, 0, "ignore");
    inject_at = -1;
    check_result(2, s, "ignore");
  endtask

  task automatic test_reset_mid();
    logic [31:0] s = '0;
    for (int k = 0; k < 5; k++) prog[k] = $urandom;
    do_start(16'd5, "rstmid");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      word_valid_i = 1'b1;
      word_data_i  = prog[i];
    end
    @(negedge clk);
    reset        = 1'b0;
    word_valid_i = 1'b1;
    word_data_i  = prog[2];
    load_start_i = 1'b1;
    load_len_i   = 16'd3;
    @(negedge clk);
    reset        = 1'b1;
    word_valid_i = 1'b0;
    load_start_i = 1'b0;
    check_reset_outputs("rstmid");
    repeat (3) @(negedge clk);
    tests++;
    if (log_addr.size() != 2) begin
      failed++;
      $display("FAIL rstmid_write_count: got %0d exp 2", log_addr.size());
    end
    for (int k = 0; k < 2 && k < log_addr.size(); k++) begin
      tests++;
      if (log_addr[k] !== BASE + 32'(4 * k) || log_data[k] !== prog[k]) begin
        failed++;
        $display("FAIL rstmid_write%0d: got %h:%h exp %h:%h", k,
                 log_addr[k], log_data[k], BASE + 32'(4 * k), prog[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin prog[k] = $urandom; s += prog[k]; end
    do_start(16'd3, "rstnew");
    stream(3, s, 1, "rstnew");
    check_result(3, s, "rstnew");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int n;
      logic [31:0] s = '0;
      logic [31:0] csw;
      n = (t == 0) ? int'(DEPTH) : $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin prog[k] = $urandom; s += prog[k]; end
      csw = ($urandom_range(0, 2) == 0) ? s + 32'($urandom_range(1, 1000)) : s;
      do_start(16'(n), "rand");
      stream(n, csw, 1, "rand");
      check_result(n, csw, "rand");
    end
  endtask

  initial begin
    reset        = 1'b0;
    load_start_i = 1'b0;
    load_len_i   = '0;
    word_valid_i = 1'b0;
    word_data_i  = '0;
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_len();
    test_stall();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
